mem_access_ctrl: RTL and testbench

- MEM-stage load/store unit and data-bus master.
- Accepts a memory request issued alongside the EX→MEM pipeline-register capture, runs a req/ack transaction on the data bus, and returns aligned, extended load data plus an exception code to writeback.
- Drives `mem_stall` back to the pipeline register while a transaction is outstanding, and honours `mem_flush`.

---
 rtl/mem_access_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM-stage load/store unit and data-bus master
//
// Accepts a load/store alongside the EX->MEM capture, runs one req/ack
// transaction on the data bus and returns aligned, extended load data or an
// exception code to writeback.
//
// Ports:
//   clk_i, rst_i         clock, asynchronous active-high reset
//   cpu_en_i             global enable; low freezes state (pulses still clear)
//   ex_en_i, ex_mem_op_i EX-stage valid and memory op (0 NONE, 1..8 LB..SW)
//   ex_addr_i, ex_wdata_i effective address and store data
//   mem_flush_i          discard the in-flight request
//   bus_req_o .. bus_wdata_o  registered data-bus request fields
//   bus_rdata_i, bus_ack_i    bus read data and single-cycle completion
//   mem_stall_o          freeze the EX->MEM register while waiting
//   ld_valid_o, ld_data_o     one-cycle load result
//   exp_code_o           one-cycle exception code (0 = none)
//   busy_o               transaction outstanding
module mem_access_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int EXP_W   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_en_i,
  input  logic              ex_en_i,
  input  logic [3:0]        ex_mem_op_i,
  input  logic [ADDR_W-1:0] ex_addr_i,
  input  logic [31:0]       ex_wdata_i,
  input  logic              mem_flush_i,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [3:0]        bus_be_o,
  output logic [31:0]       bus_wdata_o,
  input  logic [31:0]       bus_rdata_i,
  input  logic              bus_ack_i,
  output logic              mem_stall_o,
  output logic              ld_valid_o,
  output logic [31:0]       ld_data_o,
  output logic [EXP_W-1:0]  exp_code_o,
  output logic              busy_o
);

  localparam logic [3:0] OP_LB = 4'd1, OP_LH = 4'd2, OP_LW = 4'd3, OP_LBU = 4'd4,
                         OP_LHU = 4'd5, OP_SB = 4'd6, OP_SH = 4'd7, OP_SW = 4'd8;
  localparam int TMO_W = $clog2(TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [EXP_W-1:0] EXC_LD_MIS = EXP_W'(4), EXC_LD_FLT = EXP_W'(5),
                               EXC_ST_MIS = EXP_W'(6), EXC_ST_FLT = EXP_W'(7);

  typedef enum logic {IDLE = 1'b0, BUS = 1'b1} state_e;

  state_e             state_q, state_d;
  logic               discard_q, discard_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [3:0]         op_q, op_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               req_q, req_d;
  logic               we_q, we_d;
  logic [3:0]         be_q, be_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               ld_valid_q, ld_valid_d;
  logic [31:0]        ld_data_q, ld_data_d;
  logic [EXP_W-1:0]   exp_q, exp_d;

  // Request decode on the incoming EX-stage op
  logic        new_load, new_store, misaligned;
  logic [3:0]  new_be;
  logic [31:0] new_wdata;

  assign new_load  = (ex_mem_op_i >= OP_LB) && (ex_mem_op_i <= OP_LHU);
  assign new_store = (ex_mem_op_i >= OP_SB) && (ex_mem_op_i <= OP_SW);

  always_comb begin
    misaligned = 1'b0;
    new_be     = 4'b1111;
    new_wdata  = ex_wdata_i;
    case (ex_mem_op_i)
      OP_LH, OP_LHU: misaligned = ex_addr_i[0];
      OP_LW:         misaligned = |ex_addr_i[1:0];
      OP_SB: begin
        new_be    = 4'b0001 << ex_addr_i[1:0];
        new_wdata = {4{ex_wdata_i[7:0]}};
      end
      OP_SH: begin
        misaligned = ex_addr_i[0];
        new_be     = 4'b0011 << {ex_addr_i[1], 1'b0};
        new_wdata  = {2{ex_wdata_i[15:0]}};
      end
      OP_SW:         misaligned = |ex_addr_i[1:0];
      default: ;
    endcase
  end

  // Load data alignment/extension from the captured op and byte offset
  logic        cur_load;
  logic [31:0] rd_shift, rd_ext;

  assign cur_load = (op_q >= OP_LB) && (op_q <= OP_LHU);
  assign rd_shift = bus_rdata_i >> {addr_q[1:0], 3'b000};

  always_comb begin
    rd_ext = rd_shift;
    case (op_q)
      OP_LB:   rd_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
      OP_LH:   rd_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
      OP_LBU:  rd_ext = {24'd0, rd_shift[7:0]};
      OP_LHU:  rd_ext = {16'd0, rd_shift[15:0]};
      default: rd_ext = rd_shift;
    endcase
  end

  // A flush arriving in the completion cycle still suppresses the result
  logic drop;
  assign drop = discard_q | mem_flush_i;

  always_comb begin
    state_d    = state_q;
    discard_d  = discard_q;
    tmo_cnt_d  = tmo_cnt_q;
    op_d       = op_q;
    addr_d     = addr_q;
    req_d      = req_q;
    we_d       = we_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    ld_valid_d = 1'b0;
    ld_data_d  = ld_data_q;
    exp_d      = '0;
    case (state_q)
      IDLE: begin
        if (cpu_en_i && ex_en_i && (new_load || new_store) && !mem_flush_i) begin
          if (misaligned) begin
            exp_d = new_load ? EXC_LD_MIS : EXC_ST_MIS;
          end else begin
            state_d   = BUS;
            discard_d = 1'b0;
            tmo_cnt_d = '0;
            op_d      = ex_mem_op_i;
            addr_d    = ex_addr_i;
            req_d     = 1'b1;
            we_d      = new_store;
            be_d      = new_be;
            wdata_d   = new_wdata;
          end
        end
      end
      BUS: begin
        // Ack is consumed even with cpu_en low, and beats a same-cycle timeout
        if (bus_ack_i) begin
          state_d   = IDLE;
          req_d     = 1'b0;
          discard_d = 1'b0;
          tmo_cnt_d = '0;
          if (cur_load && !drop) begin
            ld_valid_d = 1'b1;
            ld_data_d  = rd_ext;
          end
        end else if (cpu_en_i) begin
          if (mem_flush_i) discard_d = 1'b1;
          if (tmo_cnt_q == TMO_LAST) begin
            state_d   = IDLE;
            req_d     = 1'b0;
            discard_d = 1'b0;
            tmo_cnt_d = '0;
            if (!drop) exp_d = cur_load ? EXC_LD_FLT : EXC_ST_FLT;
          end else begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      discard_q  <= 1'b0;
      tmo_cnt_q  <= '0;
      op_q       <= '0;
      addr_q     <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      be_q       <= '0;
      wdata_q    <= '0;
      ld_valid_q <= 1'b0;
      ld_data_q  <= '0;
      exp_q      <= '0;
    end else begin
      state_q    <= state_d;
      discard_q  <= discard_d;
      tmo_cnt_q  <= tmo_cnt_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
      we_q       <= we_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      ld_valid_q <= ld_valid_d;
      ld_data_q  <= ld_data_d;
      exp_q      <= exp_d;
    end
  end

  assign bus_req_o   = req_q;
  assign bus_we_o    = we_q;
  assign bus_addr_o  = {addr_q[ADDR_W-1:2], 2'b00};
  assign bus_be_o    = be_q;
  assign bus_wdata_o = wdata_q;
  // Combinational so the pipeline register advances in the completion cycle
  assign mem_stall_o = (state_q == BUS) && !bus_ack_i && (tmo_cnt_q != TMO_LAST);
  assign ld_valid_o  = ld_valid_q;
  assign ld_data_o   = ld_data_q;
  assign exp_code_o  = exp_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - directed self-checking bench for mem_access_ctrl
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_en = 1'b1;
  logic        ex_en = 1'b0;
  logic [3:0]  ex_mem_op = 4'd0;
  logic [31:0] ex_addr = 32'd0;
  logic [31:0] ex_wdata = 32'd0;
  logic        mem_flush = 1'b0;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata = 32'd0;
  logic        bus_ack = 1'b0;
  logic        mem_stall, ld_valid, busy;
  logic [31:0] ld_data;
  logic [3:0]  exp_code;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_access_ctrl dut (
    .clk_i(clk), .rst_i(rst), .cpu_en_i(cpu_en), .ex_en_i(ex_en),
    .ex_mem_op_i(ex_mem_op), .ex_addr_i(ex_addr), .ex_wdata_i(ex_wdata),
    .mem_flush_i(mem_flush), .bus_req_o(bus_req), .bus_we_o(bus_we),
    .bus_addr_o(bus_addr), .bus_be_o(bus_be), .bus_wdata_o(bus_wdata),
    .bus_rdata_i(bus_rdata), .bus_ack_i(bus_ack), .mem_stall_o(mem_stall),
    .ld_valid_o(ld_valid), .ld_data_o(ld_data), .exp_code_o(exp_code),
    .busy_o(busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one op, acks it after ack_after waiting cycles, and returns what was
  // observed: first-cycle bus fields, stall/req counts and the post-ack result.
  task automatic do_access(input logic [3:0] op, input logic [31:0] addr,
                           input logic [31:0] wdata, input int ack_after,
                           input logic [31:0] rdata, output int stall_cnt,
                           output int req_cnt, output logic [3:0] be,
                           output logic we, output logic [31:0] baddr,
                           output logic [31:0] bwdata, output logic lv,
                           output logic [31:0] ld, output logic [3:0] exc);
    ex_en = 1'b1; ex_mem_op = op; ex_addr = addr; ex_wdata = wdata;
    step();
    ex_en = 1'b0; ex_mem_op = 4'd0;
    be = bus_be; we = bus_we; baddr = bus_addr; bwdata = bus_wdata;
    stall_cnt = 0; req_cnt = 0;
    for (int i = 0; i < ack_after; i++) begin
      @(negedge clk);
      stall_cnt += int'(mem_stall);
      req_cnt   += int'(bus_req);
      step();
    end
    bus_ack = 1'b1; bus_rdata = rdata;
    @(negedge clk);
    stall_cnt += int'(mem_stall);
    req_cnt   += int'(bus_req);
    step();
    bus_ack = 1'b0;
    lv = ld_valid; ld = ld_data; exc = exp_code;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++;
    if ({bus_req, bus_we, bus_addr, bus_be, bus_wdata} !== 70'd0) begin
      n_fail++; $display("FAIL reset_bus: got %h want 0", {bus_req, bus_we, bus_addr, bus_be, bus_wdata});
    end
    n_cmp++;
    if ({mem_stall, ld_valid, ld_data, exp_code, busy} !== 39'd0) begin
      n_fail++; $display("FAIL reset_out: got %h want 0", {mem_stall, ld_valid, ld_data, exp_code, busy});
    end
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_loads();
    int sc, rc; logic [3:0] be, exc; logic we, lv; logic [31:0] ba, bw, ld;
    do_access(4'd3, 32'h100, 32'h0, 2, 32'hDEADBEEF, sc, rc, be, we, ba, bw, lv, ld, exc);
    n_cmp++; if (be !== 4'b1111) begin n_fail++; $display("FAIL lw_be: got %b want 1111", be); end
    n_cmp++; if (we !== 1'b0) begin n_fail++; $display("FAIL lw_we: got %b want 0", we); end
    n_cmp++; if (ba !== 32'h100) begin n_fail++; $display("FAIL lw_addr: got %h want 100", ba); end
    n_cmp++; if (sc !== 2) begin n_fail++; $display("FAIL lw_stall_cycles: got %0d want 2", sc); end
    n_cmp++; if (rc !== 3) begin n_fail++; $display("FAIL lw_req_cycles: got %0d want 3", rc); end
    n_cmp++; if (lv !== 1'b1) begin n_fail++; $display("FAIL lw_ld_valid: got %b want 1", lv); end
    n_cmp++; if (ld !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_data: got %h want deadbeef", ld); end
    n_cmp++; if (busy !== 1'b0 || bus_req !== 1'b0) begin n_fail++; $display("FAIL lw_idle: got busy=%b req=%b want 0 0", busy, bus_req); end
    step();
    n_cmp++; if (ld_valid !== 1'b0) begin n_fail++; $display("FAIL lw_pulse: got %b want 0", ld_valid); end

    do_access(4'd1, 32'h103, 32'h0, 1, 32'h80123456, sc, rc, be, we, ba, bw, lv, ld, exc);
    n_cmp++; if (ld !== 32'hFFFFFF80 || lv !== 1'b1) begin n_fail++; $display("FAIL lb_sign: got %h/%b want ffffff80/1", ld, lv); end
    step();
    do_access(4'd4, 32'h103, 32'h0, 1, 32'h80123456, sc, rc, be, we, ba, bw, lv, ld, exc);
    n_cmp++; if (ld !== 32'h00000080) begin n_fail++; $display("FAIL lbu_zero: got %h want 00000080", ld); end
    n_cmp++; if (ba !== 32'h100) begin n_fail++; $display("FAIL lbu_addr: got %h want 100", ba); end
    step();
    do_access(4'd2, 32'h102, 32'h0, 0, 32'h8001ABCD, sc, rc, be, we, ba, bw, lv, ld, exc);
    n_cmp++; if (ld !== 32'hFFFF8001) begin n_fail++; $display("FAIL lh_sign: got %h want ffff8001", ld); end
    step();
    do_access(4'd5, 32'h102, 32'h0, 0, 32'h8001ABCD, sc, rc, be, we, ba, bw, lv, ld, exc);
    n_cmp++; if (ld !== 32'h00008001) begin n_fail++; $display("FAIL lhu_zero: got %h want 00008001", ld); end
    step();
  endtask

  task automatic test_stores();
    int sc, rc; logic [3:0] be, exc; logic we, lv; logic [31:0] ba, bw, ld;
    do_access(4'd7, 32'h202, 32'h1234ABCD, 1, 32'h0, sc, rc, be, we, ba, bw, lv, ld, exc);
    n_cmp++; if (we !== 1'b1) begin n_fail++; $display("FAIL sh_we: got %b want 1", we); end
    n_cmp++; if (be !== 4'b1100) begin n_fail++; $display("FAIL sh_be: got %b want 1100", be); end
    n_cmp++; if (bw !== 32'hABCDABCD) begin n_fail++; $display("FAIL sh_wdata: got %h want abcdabcd", bw); end
    n_cmp++; if (ba !== 32'h200) begin n_fail++; $display("FAIL sh_addr: got %h want 200", ba); end
    n_cmp++; if (lv !== 1'b0 || exc !== 4'd0) begin n_fail++; $display("FAIL sh_no_result: got lv=%b exc=%0d want 0 0", lv, exc); end
    step();
    do_access(4'd6, 32'h301, 32'h0000005A, 0, 32'h0, sc, rc, be, we, ba, bw, lv, ld, exc);
    n_cmp++; if (be !== 4'b0010) begin n_fail++; $display("FAIL sb_be: got %b want 0010", be); end
    n_cmp++; if (bw !== 32'h5A5A5A5A) begin n_fail++; $display("FAIL sb_wdata: got %h want 5a5a5a5a", bw); end
    step();
    do_access(4'd8, 32'h304, 32'hCAFEF00D, 0, 32'h0, sc, rc, be, we, ba, bw, lv, ld, exc);
    n_cmp++; if (be !== 4'b1111 || bw !== 32'hCAFEF00D) begin n_fail++; $display("FAIL sw_fields: got %b/%h want 1111/cafef00d", be, bw); end
    step();
  endtask

  task automatic test_misaligned();
    logic [3:0] ops [2];
    logic [31:0] adrs [2];
    logic [3:0] want [2];
    ops[0] = 4'd3; adrs[0] = 32'h101; want[0] = 4'd4;
    ops[1] = 4'd7; adrs[1] = 32'h001; want[1] = 4'd6;
    for (int k = 0; k < 2; k++) begin
      ex_en = 1'b1; ex_mem_op = ops[k]; ex_addr = adrs[k];
      @(negedge clk);
      n_cmp++; if (mem_stall !== 1'b0) begin n_fail++; $display("FAIL mis_stall0_%0d: got %b want 0", k, mem_stall); end
      step();
      ex_en = 1'b0; ex_mem_op = 4'd0;
      @(negedge clk);
      n_cmp++; if (bus_req !== 1'b0 || mem_stall !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL mis_nobus_%0d: got req=%b stall=%b busy=%b want 0 0 0", k, bus_req, mem_stall, busy);
      end
      n_cmp++; if (exp_code !== want[k]) begin n_fail++; $display("FAIL mis_exp_%0d: got %0d want %0d", k, exp_code, want[k]); end
      step();
      n_cmp++; if (exp_code !== 4'd0) begin n_fail++; $display("FAIL mis_pulse_%0d: got %0d want 0", k, exp_code); end
    end
  endtask

  task automatic test_timeout();
    int rc, sc; logic last_stall;
    ex_en = 1'b1; ex_mem_op = 4'd3; ex_addr = 32'h300;
    step();
    ex_en = 1'b0; ex_mem_op = 4'd0;
    rc = 0; sc = 0; last_stall = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (bus_req !== 1'b1) break;
      @(negedge clk);
      rc++; sc += int'(mem_stall); last_stall = mem_stall;
      step();
    end
    n_cmp++; if (rc !== 16) begin n_fail++; $display("FAIL tmo_req_cycles: got %0d want 16", rc); end
    n_cmp++; if (sc !== 15) begin n_fail++; $display("FAIL tmo_stall_cycles: got %0d want 15", sc); end
    n_cmp++; if (last_stall !== 1'b0) begin n_fail++; $display("FAIL tmo_last_stall: got %b want 0", last_stall); end
    n_cmp++; if (exp_code !== 4'd5) begin n_fail++; $display("FAIL tmo_exp: got %0d want 5", exp_code); end
    n_cmp++; if (ld_valid !== 1'b0) begin n_fail++; $display("FAIL tmo_no_ld: got %b want 0", ld_valid); end
    step();
    n_cmp++; if (exp_code !== 4'd0) begin n_fail++; $display("FAIL tmo_pulse: got %0d want 0", exp_code); end
  endtask

  task automatic test_ack_at_timeout();
    int sc, rc; logic [3:0] be, exc; logic we, lv; logic [31:0] ba, bw, ld;
    do_access(4'd3, 32'h310, 32'h0, 15, 32'h13579BDF, sc, rc, be, we, ba, bw, lv, ld, exc);
    n_cmp++; if (lv !== 1'b1 || ld !== 32'h13579BDF || exc !== 4'd0) begin
      n_fail++; $display("FAIL ack_wins: got lv=%b ld=%h exc=%0d want 1 13579bdf 0", lv, ld, exc);
    end
    step();
  endtask

  task automatic test_cpu_en_freeze();
    int rc;
    ex_en = 1'b1; ex_mem_op = 4'd3; ex_addr = 32'h320;
    step();
    ex_en = 1'b0; ex_mem_op = 4'd0;
    rc = 0;
    for (int i = 0; i < 60; i++) begin
      if (bus_req !== 1'b1) break;
      if (rc == 1) cpu_en = 1'b0;
      if (rc == 4) cpu_en = 1'b1;
      @(negedge clk);
      rc++;
      step();
    end
    cpu_en = 1'b1;
    n_cmp++; if (rc !== 19) begin n_fail++; $display("FAIL freeze_req_cycles: got %0d want 19", rc); end
    n_cmp++; if (exp_code !== 4'd5) begin n_fail++; $display("FAIL freeze_exp: got %0d want 5", exp_code); end
    step();
  endtask

  task automatic test_flush();
    int sc, rc, hold; logic [3:0] be, exc; logic we, lv; logic [31:0] ba, bw, ld;
    ex_en = 1'b1; ex_mem_op = 4'd3; ex_addr = 32'h400;
    step();
    ex_en = 1'b0; ex_mem_op = 4'd0;
    hold = 0;
    for (int c = 1; c <= 4; c++) begin
      mem_flush = (c == 2);
      if (c == 4) begin bus_ack = 1'b1; bus_rdata = 32'h11111111; end
      @(negedge clk);
      if (c < 4) hold += int'(mem_stall);
      else begin
        n_cmp++; if (mem_stall !== 1'b0) begin n_fail++; $display("FAIL flush_ack_stall: got %b want 0", mem_stall); end
      end
      step();
    end
    mem_flush = 1'b0; bus_ack = 1'b0;
    n_cmp++; if (hold !== 3) begin n_fail++; $display("FAIL flush_stall_held: got %0d want 3", hold); end
    n_cmp++; if (ld_valid !== 1'b0 || exp_code !== 4'd0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL flush_discard: got lv=%b exc=%0d busy=%b want 0 0 0", ld_valid, exp_code, busy);
    end
    do_access(4'd3, 32'h404, 32'h0, 0, 32'h22222222, sc, rc, be, we, ba, bw, lv, ld, exc);
    n_cmp++; if (lv !== 1'b1 || ld !== 32'h22222222) begin n_fail++; $display("FAIL flush_next_lw: got %b/%h want 1/22222222", lv, ld); end
    step();
  endtask

  task automatic test_back_to_back();
    ex_en = 1'b1; ex_mem_op = 4'd3; ex_addr = 32'h500;
    step();
    // Keep the next request presented through the ack cycle and beyond
    ex_addr = 32'h504;
    bus_ack = 1'b1; bus_rdata = 32'hA5A5A5A5;
    step();
    bus_ack = 1'b0;
    n_cmp++; if (bus_req !== 1'b0 || ld_valid !== 1'b1) begin
      n_fail++; $display("FAIL b2b_gap: got req=%b lv=%b want 0 1", bus_req, ld_valid);
    end
    step();
    ex_en = 1'b0; ex_mem_op = 4'd0;
    n_cmp++; if (bus_req !== 1'b1 || bus_addr !== 32'h504) begin
      n_fail++; $display("FAIL b2b_next_req: got req=%b addr=%h want 1 504", bus_req, bus_addr);
    end
    bus_ack = 1'b1; bus_rdata = 32'h5A5A5A5A;
    step();
    bus_ack = 1'b0;
    n_cmp++; if (ld_data !== 32'h5A5A5A5A || ld_valid !== 1'b1) begin
      n_fail++; $display("FAIL b2b_data: got %h/%b want 5a5a5a5a/1", ld_data, ld_valid);
    end
    step();
  endtask

  task automatic test_reset_mid();
    ex_en = 1'b1; ex_mem_op = 4'd3; ex_addr = 32'h600;
    step();
    ex_en = 1'b0; ex_mem_op = 4'd0;
    step();
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++; if (bus_req !== 1'b0 || mem_stall !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_async: got req=%b stall=%b busy=%b want 0 0 0", bus_req, mem_stall, busy);
    end
    step();
    rst = 1'b0;
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    step();
    n_cmp++; if (ld_valid !== 1'b0 || exp_code !== 4'd0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_no_result: got lv=%b exc=%0d busy=%b want 0 0 0", ld_valid, exp_code, busy);
    end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_stores();
    test_misaligned();
    test_timeout();
    test_ack_at_timeout();
    test_cpu_en_freeze();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
